// File: rtl/ready_bit_ram_cfg_if.sv
// ready_bit_ram_cfg_if
// Bus bundle between the Active List and the ready/status-bit RAM.
//   addr_i            commit-lane read addresses, packed INDEX bits per port
//   data_o            read data, packed WIDTH bits per port
//   addrWr_i          write addresses, packed INDEX bits per port
//   dataWr_i          write data, packed WIDTH bits per port
//   wrEn_i            per-port write enable
//   writePortGated_i  1 = write port powered off
//   readPortGated_i   1 = read port powered off
//   partitionGated_i  1 = partition powered off
//   ramReady_o        1 = clear sweep finished, contents valid
// master = Active List side, slave = RAM side.
interface ready_bit_ram_cfg_if #(
  parameter int NUM_RD_PORTS = 4,
  parameter int NUM_WR_PORTS = 9,
  parameter int INDEX        = 7,
  parameter int WIDTH        = 1,
  parameter int NUM_PARTS    = 4
);
  logic [NUM_RD_PORTS*INDEX-1:0] addr_i;
  logic [NUM_RD_PORTS*WIDTH-1:0] data_o;
  logic [NUM_WR_PORTS*INDEX-1:0] addrWr_i;
  logic [NUM_WR_PORTS*WIDTH-1:0] dataWr_i;
  logic [NUM_WR_PORTS-1:0]       wrEn_i;
  logic [NUM_WR_PORTS-1:0]       writePortGated_i;
  logic [NUM_RD_PORTS-1:0]       readPortGated_i;
  logic [NUM_PARTS-1:0]          partitionGated_i;
  logic                          ramReady_o;

  modport master (
    output addr_i, addrWr_i, dataWr_i, wrEn_i,
    output writePortGated_i, readPortGated_i, partitionGated_i,
    input  data_o, ramReady_o
  );

  modport slave (
    input  addr_i, addrWr_i, dataWr_i, wrEn_i,
    input  writePortGated_i, readPortGated_i, partitionGated_i,
    output data_o, ramReady_o
  );
endinterface

// File: rtl/ready_bit_ram_cfg.sv
// ready_bit_ram_cfg
// Multi-port ready/status-bit RAM for the Active List with runtime port and
// partition gating. After reset, or whenever the partition gating pattern
// changes, a clear engine sweeps CLR_ROWS rows per cycle to RESET_VAL; while
// it runs ramReady_o is low, all writes are dropped and all reads return 0.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    ready_bit_ram_cfg_if slave modport (read/write lanes, gating,
//          ramReady_o)
module ready_bit_ram_cfg #(
  parameter int NUM_RD_PORTS  = 4,
  parameter int NUM_WR_PORTS  = 9,
  parameter int DEPTH         = 128,
  parameter int INDEX         = 7,
  parameter int WIDTH         = 1,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int CLR_ROWS      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset,
  ready_bit_ram_cfg_if.slave bus
);

  localparam int PW = INDEX + 1;
  localparam logic [PW-1:0] LAST_GROUP = PW'(DEPTH - CLR_ROWS);
  localparam logic [PW-1:0] CLR_STEP   = PW'(CLR_ROWS);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        clr_ptr_q, clr_ptr_d;
  logic                 ready_q, ready_d;
  logic [NUM_PARTS-1:0] part_gated_q;
  logic                 part_change;

  logic [WIDTH-1:0] ram [DEPTH];

  logic [INDEX-1:0]             wr_addr [NUM_WR_PORTS];
  logic [WIDTH-1:0]             wr_data [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0]      wr_ok;
  logic [NUM_RD_PORTS*WIDTH-1:0] rd_data;

  // Partition is selected by the top address bits.
  function automatic logic [NUM_PARTS_LOG-1:0] part_of(input logic [INDEX-1:0] a);
    return a[INDEX-1 -: NUM_PARTS_LOG];
  endfunction

  assign part_change = (bus.partitionGated_i != part_gated_q);

  // State register. The gating snapshot is taken every cycle, including
  // during reset, so a pattern held through reset does not retrigger a sweep.
  always_ff @(posedge clk) begin
    part_gated_q <= bus.partitionGated_i;
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic. A gating change restarts the sweep from row 0 whether
  // it arrives in READY or in the middle of an ongoing CLEAR.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        if (part_change) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == LAST_GROUP) begin
          state_d   = READY;
          ready_d   = 1'b1;
          clr_ptr_d = clr_ptr_q + CLR_STEP;
        end else begin
          clr_ptr_d = clr_ptr_q + CLR_STEP;
        end
      end
      READY: begin
        if (part_change) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // Unpack write lanes and decide which ones are allowed to land.
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      wr_addr[p] = bus.addrWr_i[p*INDEX +: INDEX];
      wr_data[p] = bus.dataWr_i[p*WIDTH +: WIDTH];
      wr_ok[p]   = bus.wrEn_i[p] & ~bus.writePortGated_i[p]
                 & ~bus.partitionGated_i[part_of(wr_addr[p])];
    end
  end

  // Array update. Contents are frozen while reset is high. In CLEAR the
  // sweep owns the array and every lane write is dropped. In READY lanes are
  // applied in ascending order so the highest-index port wins a conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        for (int r = 0; r < CLR_ROWS; r++) begin
          ram[clr_ptr_q[INDEX-1:0] + INDEX'(r)] <= RESET_VAL;
        end
      end else begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_ok[p]) begin
            ram[wr_addr[p]] <= wr_data[p];
          end
        end
      end
    end
  end

  // Combinational reads of the pre-edge array; gated ports, gated partitions
  // and a not-yet-ready array all read as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      if (ready_q && !bus.readPortGated_i[k] &&
          !bus.partitionGated_i[part_of(bus.addr_i[k*INDEX +: INDEX])]) begin
        rd_data[k*WIDTH +: WIDTH] = ram[bus.addr_i[k*INDEX +: INDEX]];
      end
    end
  end

  assign bus.data_o     = rd_data;
  assign bus.ramReady_o = ready_q;

endmodule

// File: tb/tb_ready_bit_ram_cfg.sv
// tb_ready_bit_ram_cfg
// Directed scoreboard bench for ready_bit_ram_cfg. Stimulus pushes the
// expected value of an output into a queue; a monitor on the falling edge
// pops and compares everything queued for that cycle.
module tb_ready_bit_ram_cfg;

  localparam int NUM_RD_PORTS  = 4;
  localparam int NUM_WR_PORTS  = 9;
  localparam int DEPTH         = 128;
  localparam int INDEX         = 7;
  localparam int WIDTH         = 1;
  localparam int NUM_PARTS     = 4;
  localparam int NUM_PARTS_LOG = 2;
  localparam int CLR_ROWS      = 4;
  localparam int SWEEP_CYCLES  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ready_bit_ram_cfg_if #(
    .NUM_RD_PORTS(NUM_RD_PORTS), .NUM_WR_PORTS(NUM_WR_PORTS),
    .INDEX(INDEX), .WIDTH(WIDTH), .NUM_PARTS(NUM_PARTS)
  ) bus ();

  ready_bit_ram_cfg #(
    .NUM_RD_PORTS(NUM_RD_PORTS), .NUM_WR_PORTS(NUM_WR_PORTS),
    .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_PARTS(NUM_PARTS),
    .NUM_PARTS_LOG(NUM_PARTS_LOG), .CLR_ROWS(CLR_ROWS), .RESET_VAL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string name;
    bit    is_ready;
    int    port;
    logic  exp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Advance to just after the next rising edge(s).
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic act;
    act = e.is_ready ? bus.ramReady_o : bus.data_o[e.port];
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
  endtask

  task automatic drive_write(input int p, input int addr, input logic d);
    bus.wrEn_i[p] = 1'b1;
    bus.addrWr_i[p*INDEX +: INDEX] = INDEX'(addr);
    bus.dataWr_i[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_writes();
    bus.wrEn_i = '0;
  endtask

  task automatic set_read(input int k, input int addr);
    bus.addr_i[k*INDEX +: INDEX] = INDEX'(addr);
  endtask

  task automatic expect_data(input string name, input int k, input logic v);
    sb.push_back('{name, 1'b0, k, v});
  endtask

  task automatic expect_ready(input string name, input logic v);
    sb.push_back('{name, 1'b1, 0, v});
  endtask

  // ramReady_o low for exactly SWEEP_CYCLES samples, reads forced to 0,
  // then high on the next sample.
  task automatic sweep_check(input string name);
    for (int i = 0; i < SWEEP_CYCLES; i++) begin
      expect_ready({name, " ready low"}, 1'b0);
      expect_data({name, " read zero"}, 0, 1'b0);
      applyStimulus(1);
    end
    expect_ready({name, " ready high"}, 1'b1);
  endtask

  // Monitor: compare everything queued for this cycle on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.addr_i = '0;
    bus.addrWr_i = '0;
    bus.dataWr_i = '0;
    bus.wrEn_i = '0;
    bus.writePortGated_i = '0;
    bus.readPortGated_i = '0;
    bus.partitionGated_i = '0;
    reset = 1'b1;

    // Reset for three cycles, then the initial sweep.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      expect_ready("reset ready", 1'b0);
      expect_data("reset data", 0, 1'b0);
    end
    reset = 1'b0;
    sweep_check("sweep0");

    // Write lands on the next edge; read shows old value before it.
    set_read(0, 5);
    drive_write(0, 5, 1'b1);
    expect_data("wr5 pre", 0, 1'b0);
    applyStimulus(1);
    clear_writes();
    expect_data("wr5 post", 0, 1'b1);

    // Same-address conflict: highest port wins.
    set_read(1, 9);
    drive_write(0, 9, 1'b1);
    drive_write(8, 9, 1'b0);
    applyStimulus(1);
    clear_writes();
    expect_data("conflict p8 zero", 1, 1'b0);
    drive_write(0, 9, 1'b0);
    drive_write(8, 9, 1'b1);
    applyStimulus(1);
    clear_writes();
    expect_data("conflict p8 one", 1, 1'b1);

    // Preload addr 20.
    set_read(2, 20);
    drive_write(3, 20, 1'b1);
    applyStimulus(1);
    clear_writes();
    expect_data("preload", 2, 1'b1);

    // Reconfiguration 0000 -> 1100 in READY; port-1 writes in the window drop.
    bus.partitionGated_i = 4'b1100;
    expect_ready("reconfig pre", 1'b1);
    applyStimulus(1);
    drive_write(1, 16, 1'b1);
    set_read(0, 16);
    sweep_check("reconfig");
    clear_writes();
    expect_data("reconfig write dropped", 0, 1'b0);
    expect_data("reconfig cleared 20", 2, 1'b0);
    set_read(1, 5);
    expect_data("reconfig cleared 5", 1, 1'b0);
    applyStimulus(1);

    // Preload again, then reset with partition 3 gated and abort mid-sweep.
    bus.partitionGated_i = 4'b0000;
    applyStimulus(1);
    applyStimulus(SWEEP_CYCLES);
    expect_ready("ungate ready", 1'b1);
    drive_write(3, 20, 1'b1);
    applyStimulus(1);
    clear_writes();
    expect_data("preload2", 2, 1'b1);

    bus.partitionGated_i = 4'b1000;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      expect_ready("reset2 ready", 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_ready("abort sweep low", 1'b0);
      applyStimulus(1);
    end
    reset = 1'b1;
    applyStimulus(1);
    expect_ready("mid reset ready", 1'b0);
    reset = 1'b0;
    sweep_check("restart");
    expect_data("preload cleared by reset", 2, 1'b0);

    // Gated partition 3 drops writes and reads 0.
    set_read(0, 'h70);
    drive_write(0, 'h70, 1'b1);
    applyStimulus(1);
    clear_writes();
    expect_data("gated part write", 0, 1'b0);

    // Gated write port drops; ungated it lands.
    bus.writePortGated_i[2] = 1'b1;
    drive_write(2, 30, 1'b1);
    set_read(1, 30);
    applyStimulus(1);
    clear_writes();
    expect_data("gated wport", 1, 1'b0);
    bus.writePortGated_i[2] = 1'b0;
    drive_write(2, 30, 1'b1);
    applyStimulus(1);
    clear_writes();
    expect_data("wport ungated", 1, 1'b1);

    // Ungated partition 2 still works.
    drive_write(4, 'h50, 1'b1);
    set_read(2, 'h50);
    applyStimulus(1);
    clear_writes();
    expect_data("part2 write", 2, 1'b1);

    // Read port gating.
    set_read(3, 30);
    bus.readPortGated_i[3] = 1'b1;
    expect_data("rport gated", 3, 1'b0);
    applyStimulus(1);
    bus.readPortGated_i[3] = 1'b0;
    expect_data("rport open", 3, 1'b1);
    applyStimulus(2);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ready_bit_ram_cfg.md
Name: ready_bit_ram_cfg

Overview:
- Parametrised multi-port ready/status-bit RAM for the Active List, replacing the fixed-width ALREADY_RAM.
- Issue and commit lanes write completion bits; commit lanes read them.
- Adds: runtime write-port, read-port and partition gating (DYNAMIC_CONFIG); a sequential clear engine that sweeps the array after reset or after a partition-configuration change; a ready handshake that tells the AL when the bits are valid.

Parameters:
NUM_RD_PORTS, 4, commit read ports
NUM_WR_PORTS, 9, write ports (issue lanes first, then commit lanes)
DEPTH, 128, entries; must equal 2**INDEX
INDEX, 7, address width
WIDTH, 1, bits per entry
NUM_PARTS, 4, partitions; power of two, divides DEPTH
NUM_PARTS_LOG, 2, log2(NUM_PARTS)
CLR_ROWS, 4, rows cleared per sweep cycle; power of two, divides DEPTH
RESET_VAL, 0, value every entry takes during a sweep

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
addr_i  in  NUM_RD_PORTS*INDEX  read addresses, packed; port k is bits [k*INDEX +: INDEX]
data_o  out  NUM_RD_PORTS*WIDTH  read data, packed
addrWr_i  in  NUM_WR_PORTS*INDEX  write addresses, packed
dataWr_i  in  NUM_WR_PORTS*WIDTH  write data, packed
wrEn_i  in  NUM_WR_PORTS  per-port write enable
writePortGated_i  in  NUM_WR_PORTS  1 = write port powered off
readPortGated_i  in  NUM_RD_PORTS  1 = read port powered off
partitionGated_i  in  NUM_PARTS  1 = partition powered off
ramReady_o  out  1  1 = sweep complete, array contents valid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Partition mapping: partition of an address = addr[INDEX-1 -: NUM_PARTS_LOG]. Each partition holds DEPTH/NUM_PARTS rows.
- States: CLEAR and READY.
- Reset: while reset=1, state<=CLEAR, clrPtr<=0, ramReady_o<=0, partGatedQ<=partitionGated_i. Array contents are left unchanged during reset.
- CLEAR:
  - Each cycle, rows clrPtr .. clrPtr+CLR_ROWS-1 are written to RESET_VAL; clrPtr increments by CLR_ROWS.
  - The sweep covers every row, gated partitions included.
  - On the cycle that writes the last group (clrPtr = DEPTH-CLR_ROWS): state<=READY, ramReady_o<=1 (registered, so it rises on the following edge).
  - Sweep length: DEPTH/CLR_ROWS cycles after reset deasserts.
- READY:
  - ramReady_o=1.
  - A write from port p occurs when wrEn_i[p]=1, writePortGated_i[p]=0, and the target partition is not gated.
  - Writes land at the next rising edge.
- Partition reconfiguration:
  - partGatedQ registers partitionGated_i every cycle.
  - If partitionGated_i != partGatedQ while in READY: state<=CLEAR, clrPtr<=0, ramReady_o<=0 at the next edge.
  - A change seen while already in CLEAR restarts the sweep (clrPtr<=0).
- Writes during CLEAR are all dropped, including commit-lane writes; the AL must stall on ramReady_o=0.
- Write conflicts: multiple enabled ports writing the same address in one cycle resolve to the highest-index port (commit lanes override issue lanes).
- Reads:
  - Combinational, no write-to-read bypass: a read returns the pre-edge value.
  - data_o[k] = 0 if readPortGated_i[k]=1, the addressed partition is gated, or ramReady_o=0; otherwise ram[addr].
- Reset values: ramReady_o=0; data_o=0 (forced by ramReady_o=0).
- Reset asserted mid-sweep: the sweep aborts and restarts from row 0 once reset falls.
- clrPtr is INDEX+1 bits wide so it cannot wrap.

Test Plan:
- Reset for 3 cycles, then release -> ramReady_o=0 for exactly 32 cycles (DEPTH=128, CLR_ROWS=4), 1 on cycle 33; all reads return 0; an entry preloaded with 1 before reset reads 0 afterwards.
- READY: port0 writes 1 to addr 5 at cycle t -> data_o[0] with addr_i[0]=5 reads 0 during t, 1 at t+1.
- Same cycle: port0 writes 1 and port8 writes 0 to addr 9 -> addr 9 reads 0; swap the data values -> reads 1.
- Write to addr 0x70 (partition 3) with partitionGated_i=4'b1000 held since reset -> write dropped, read returns 0; writePortGated_i[2]=1 with wrEn_i[2]=1 -> no update.
- In READY, change partitionGated_i 4'b0000->4'b1100 -> ramReady_o falls next edge; 32-cycle sweep; port-1 writes in that window are ignored; ramReady_o returns to 1.
- Assert reset at sweep cycle 10 for 1 cycle -> the full 32-cycle sweep restarts; ramReady_o does not rise early.
